sram_req_resp_adapter: RTL and testbench

- Val/rdy front-end placed directly upstream of SramGenericPRTL.
- Turns cache-side memory requests (read/write, byte mask) into SRAM port signals (A1/CSB1/WEB1/I1/WBM1/OEB1/CE1).
- Captures the 1-cycle-latency SRAM read data and returns ordered responses through a small response queue.
- Credit logic guarantees that no SRAM read data is lost under response backpressure.

---
 rtl/sram_req_resp_adapter_if.sv | 32 +++
 rtl/sram_req_resp_adapter.sv | 125 ++++++++++++
 tb/tb_sram_req_resp_adapter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_resp_adapter_if.sv
// Request/response handshake bundle between a cache and sram_req_resp_adapter.
// master = cache side issuing requests, slave = adapter.
interface sram_req_resp_adapter_if #(
    parameter int num_bits = 128,
    parameter int aw       = 8
);
    logic                  req_val;
    logic                  req_rdy;
    logic                  req_type;
    logic [aw-1:0]         req_addr;
    logic [num_bits-1:0]   req_data;
    logic [num_bits/8-1:0] req_wmask;
    logic [7:0]            req_opaque;

    logic                  resp_val;
    logic                  resp_rdy;
    logic                  resp_type;
    logic [7:0]            resp_opaque;
    logic [num_bits-1:0]   resp_data;

    modport master (
        output req_val, req_type, req_addr, req_data, req_wmask, req_opaque,
        output resp_rdy,
        input  req_rdy, resp_val, resp_type, resp_opaque, resp_data
    );

    modport slave (
        input  req_val, req_type, req_addr, req_data, req_wmask, req_opaque,
        input  resp_rdy,
        output req_rdy, resp_val, resp_type, resp_opaque, resp_data
    );
endinterface

// File: rtl/sram_req_resp_adapter.sv
// Val/rdy front-end for a 1-cycle-latency SRAM with an ordered response queue.
// Optional macro SRAM_ADAPTER_RDY_BYPASS_EN lets a same-cycle dequeue free a credit.
module sram_req_resp_adapter #(
    parameter int num_bits   = 128,
    parameter int num_words  = 256,
    parameter int resp_depth = 2,
    localparam int AW        = $clog2(num_words)
) (
    input  logic                clk,
    input  logic                reset,
    sram_req_resp_adapter_if.slave bus,
    output logic [AW-1:0]       sram_A1,
    output logic                sram_CE1,
    output logic                sram_CSB1,
    output logic                sram_WEB1,
    output logic [num_bits-1:0] sram_I1,
    output logic [num_bits-1:0] sram_WBM1,
    output logic                sram_OEB1,
    input  logic [num_bits-1:0] sram_O1
);
    localparam int MW = num_bits / 8;
    localparam int CW = $clog2(resp_depth + 1);
    localparam int PW = (resp_depth > 1) ? $clog2(resp_depth) : 1;

    typedef struct packed {
        logic                typ;
        logic [7:0]          opq;
        logic [num_bits-1:0] data;
    } entry_t;

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          s1_val_q, s1_val_d;
    logic          s1_type_q, s1_type_d;
    logic [7:0]    s1_opq_q, s1_opq_d;
    entry_t        mem_q [resp_depth];
    entry_t        mem_d [resp_depth];

    logic          fire;
    logic          enq;
    logic          deq;
    logic [CW:0]   used;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(resp_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits in use: queued entries plus the read in flight
    always_comb begin
        used = (CW+1)'(count_q) + (CW+1)'(s1_val_q);
`ifdef SRAM_ADAPTER_RDY_BYPASS_EN
        used = used - (CW+1)'(bus.resp_val & bus.resp_rdy);
`endif
    end

    assign bus.req_rdy = reset & (used < (CW+1)'(resp_depth));
    assign fire        = bus.req_val & bus.req_rdy;
    assign enq         = s1_val_q;
    assign deq         = bus.resp_val & bus.resp_rdy;

    assign sram_CE1  = 1'b1;
    assign sram_CSB1 = ~fire;
    assign sram_WEB1 = ~(fire & bus.req_type);
    assign sram_A1   = bus.req_addr;
    assign sram_I1   = bus.req_data;
    assign sram_OEB1 = ~(s1_val_q & ~s1_type_q);

    // Expand byte enables to the SRAM bit mask, only for a firing write
    always_comb begin
        sram_WBM1 = '0;
        for (int i = 0; i < MW; i++) begin
            sram_WBM1[i*8 +: 8] = {8{fire & bus.req_type & bus.req_wmask[i]}};
        end
    end

    assign bus.resp_val    = (count_q != '0);
    assign bus.resp_type   = mem_q[head_q].typ;
    assign bus.resp_opaque = mem_q[head_q].opq;
    assign bus.resp_data   = mem_q[head_q].data;

    // Stage-1 capture, queue pointers and occupancy
    always_comb begin
        s1_val_d  = fire;
        s1_type_d = fire ? bus.req_type : s1_type_q;
        s1_opq_d  = fire ? bus.req_opaque : s1_opq_q;
        count_d   = count_q + CW'(enq) - CW'(deq);
        tail_d    = enq ? wrap_inc(tail_q) : tail_q;
        head_d    = deq ? wrap_inc(head_q) : head_q;
        mem_d     = mem_q;
        if (enq) begin
            mem_d[tail_q].typ  = s1_type_q;
            mem_d[tail_q].opq  = s1_opq_q;
            mem_d[tail_q].data = s1_type_q ? '0 : sram_O1;
        end
    end

    // Control state, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            s1_val_q  <= 1'b0;
            s1_type_q <= 1'b0;
            s1_opq_q  <= '0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            s1_val_q  <= s1_val_d;
            s1_type_q <= s1_type_d;
            s1_opq_q  <= s1_opq_d;
        end
    end

    // Queue payload storage; contents are don't-care while count is zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset) enq |-> (count_q < CW'(resp_depth))
    );
endmodule

// File: tb/tb_sram_req_resp_adapter.sv
// Self-checking bench for sram_req_resp_adapter with a behavioural SRAM
// and a transaction-level response model.
module tb_sram_req_resp_adapter;
    localparam int NB  = 128;
    localparam int NW  = 256;
    localparam int DEP = 2;
    localparam int AW  = 8;
    localparam int MW  = NB / 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sram_req_resp_adapter_if #(.num_bits(NB), .aw(AW)) bus ();

    logic [AW-1:0] sram_A1;
    logic          sram_CE1, sram_CSB1, sram_WEB1, sram_OEB1;
    logic [NB-1:0] sram_I1, sram_WBM1, sram_O1;

    sram_req_resp_adapter #(
        .num_bits(NB), .num_words(NW), .resp_depth(DEP)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .sram_A1(sram_A1), .sram_CE1(sram_CE1), .sram_CSB1(sram_CSB1),
        .sram_WEB1(sram_WEB1), .sram_I1(sram_I1), .sram_WBM1(sram_WBM1),
        .sram_OEB1(sram_OEB1), .sram_O1(sram_O1)
    );

    // Behavioural SRAM: one-cycle read latency, bit-masked writes
    logic [NB-1:0] sram_mem [NW];
    always @(posedge clk) begin
        if (!sram_CSB1) begin
            if (!sram_WEB1)
                sram_mem[sram_A1] <= (sram_mem[sram_A1] & ~sram_WBM1) | (sram_I1 & sram_WBM1);
            else
                sram_O1 <= sram_mem[sram_A1];
        end
    end

    typedef struct {
        logic          typ;
        logic [7:0]    opq;
        logic [NB-1:0] data;
        int            cyc;
    } rsp_t;

    rsp_t          mq[$];
    rsp_t          got[$];
    int            fire_cyc[$];
    logic [NB-1:0] mmem [NW];
    bit            prev_rd;
    int            cyc;
    int            n_cmp;
    int            n_err;

    localparam logic [NB-1:0] DB = {4{32'hDEADBEEF}};
    localparam logic [NB-1:0] PA = {4{32'hA5A5_0001}};
    localparam logic [NB-1:0] PB = {4{32'h5A5A_0002}};
    localparam logic [NB-1:0] PX = {4{32'hC0DE_1234}};

    task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] expand(input logic [MW-1:0] m);
        logic [NB-1:0] r;
        r = '0;
        for (int i = 0; i < MW; i++) r[i*8 +: 8] = {8{m[i]}};
        return r;
    endfunction

    // Compare against the transaction model every cycle, then advance it
    always @(negedge clk) begin
        bit            vis, dq, rdy, fr;
        int            outst;
        rsp_t          e;
        logic [NB-1:0] wm;
        cyc++;
        chk("ce1", sram_CE1, 1);
        if (!reset) begin
            mq.delete();
            prev_rd = 0;
            chk("rst_req_rdy", bus.req_rdy, 0);
            chk("rst_resp_val", bus.resp_val, 0);
            chk("rst_csb", sram_CSB1, 1);
            chk("rst_oeb", sram_OEB1, 1);
        end else begin
            vis   = (mq.size() > 0) && (mq[0].cyc <= cyc);
            dq    = vis && bus.resp_rdy;
            outst = mq.size();
`ifdef SRAM_ADAPTER_RDY_BYPASS_EN
            rdy = (outst - int'(dq)) < DEP;
`else
            rdy = outst < DEP;
`endif
            fr = bus.req_val && rdy;
            chk("req_rdy", bus.req_rdy, rdy);
            chk("resp_val", bus.resp_val, vis);
            if (vis) begin
                chk("resp_type", bus.resp_type, mq[0].typ);
                chk("resp_opaque", bus.resp_opaque, mq[0].opq);
                chk("resp_data", bus.resp_data, mq[0].data);
            end
            wm = (fr && bus.req_type) ? expand(bus.req_wmask) : '0;
            chk("csb", sram_CSB1, !fr);
            chk("web", sram_WEB1, !(fr && bus.req_type));
            chk("wbm", sram_WBM1, wm);
            chk("oeb", sram_OEB1, !prev_rd);
            if (fr) begin
                chk("a1", sram_A1, bus.req_addr);
                chk("i1", sram_I1, bus.req_data);
            end
            if (dq) begin
                e = mq.pop_front();
                e.cyc = cyc;
                got.push_back(e);
            end
            prev_rd = fr && !bus.req_type;
            if (fr) begin
                fire_cyc.push_back(cyc);
                e.typ  = bus.req_type;
                e.opq  = bus.req_opaque;
                e.data = bus.req_type ? '0 : mmem[bus.req_addr];
                e.cyc  = cyc + 2;
                if (bus.req_type)
                    mmem[bus.req_addr] = (mmem[bus.req_addr] & ~wm) | (bus.req_data & wm);
                mq.push_back(e);
            end
        end
    end

    task automatic send(input bit t, input logic [AW-1:0] a, input logic [NB-1:0] d,
                        input logic [MW-1:0] m, input logic [7:0] o);
        bit f;
        int n;
        bus.req_val    = 1'b1;
        bus.req_type   = t;
        bus.req_addr   = a;
        bus.req_data   = d;
        bus.req_wmask  = m;
        bus.req_opaque = o;
        f = 0;
        n = 0;
        while (!f && n < 50) begin
            @(negedge clk);
            f = bus.req_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accept", f, 1);
    endtask

    task automatic drain();
        int n;
        bus.req_val = 1'b0;
        n = 0;
        while (mq.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", mq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        int b, fb, nf;
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        prev_rd = 0;
        for (int i = 0; i < NW; i++) begin
            sram_mem[i] = '0;
            mmem[i] = '0;
        end
        sram_O1 = '0;
        bus.req_val = 0;
        bus.req_type = 0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.req_wmask = '0;
        bus.req_opaque = '0;
        bus.resp_rdy = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("init_req_rdy", bus.req_rdy, 0);
        chk("init_resp_val", bus.resp_val, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Write then read with latency pinned
        b = got.size();
        fb = fire_cyc.size();
        send(1, 8'h05, DB, '1, 8'h11);
        send(0, 8'h05, '0, '0, 8'h12);
        drain();
        chk("wr_resp_type", got[b].typ, 1);
        chk("wr_resp_data", got[b].data, '0);
        chk("wr_latency", got[b].cyc - fire_cyc[fb], 2);
        chk("rd_resp_data", got[b+1].data, DB);
        chk("rd_resp_opq", got[b+1].opq, 8'h12);
        chk("rd_latency", got[b+1].cyc - fire_cyc[fb+1], 2);

        // Partial write of byte 0
        b = got.size();
        send(1, 8'h07, '1, '1, 8'h21);
        send(1, 8'h07, '0, 16'h0001, 8'h22);
        send(0, 8'h07, '0, '0, 8'h23);
        drain();
        chk("partial_data", got[b+2].data, {{15{8'hFF}}, 8'h00});

        // Backpressure: only two requests may be outstanding
        b = got.size();
        bus.resp_rdy   = 0;
        bus.req_val    = 1;
        bus.req_type   = 0;
        bus.req_addr   = 8'h05;
        bus.req_opaque = 8'h31;
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            bit f;
            @(negedge clk);
            f = bus.req_rdy;
            @(posedge clk);
            #1;
            if (f) begin
                nf++;
                bus.req_opaque = bus.req_opaque + 8'd1;
            end
        end
        chk("bp_fires", nf, 2);
        chk("bp_req_rdy", bus.req_rdy, 0);
        bus.req_val  = 0;
        bus.resp_rdy = 1;
        drain();
        chk("bp_order0", got[b].opq, 8'h31);
        chk("bp_order1", got[b+1].opq, 8'h32);
        chk("bp_data1", got[b+1].data, DB);

        // Throughput: eight back-to-back reads
        b = got.size();
        fb = fire_cyc.size();
        for (int i = 0; i < 8; i++) send(0, AW'(i), '0, '0, 8'(8'h40 + i));
        drain();
`ifdef SRAM_ADAPTER_RDY_BYPASS_EN
        chk("tput_span", fire_cyc[fb+7] - fire_cyc[fb] + 1, 8);
`else
        chk("tput_span", fire_cyc[fb+7] - fire_cyc[fb] + 1, 11);
`endif
        for (int i = 0; i < 8; i++) chk("tput_order", got[b+i].opq, 8'(8'h40 + i));

        // Boundary address against address 0
        b = got.size();
        send(1, 8'hFF, PA, '1, 8'h51);
        send(1, 8'h00, PB, '1, 8'h52);
        send(0, 8'hFF, '0, '0, 8'h53);
        send(0, 8'h00, '0, '0, 8'h54);
        drain();
        chk("top_addr", got[b+2].data, PA);
        chk("addr0", got[b+3].data, PB);

        // Reset with one queued and one in flight
        send(1, 8'h10, PX, '1, 8'h61);
        drain();
        bus.resp_rdy = 0;
        send(0, 8'h10, '0, '0, 8'h62);
        send(0, 8'h10, '0, '0, 8'h63);
        chk("pre_rst_resp_val", bus.resp_val, 1);
        bus.req_val = 0;
        reset = 1'b0;
        #1;
        chk("mid_rst_resp_val", bus.resp_val, 0);
        chk("mid_rst_req_rdy", bus.req_rdy, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.resp_rdy = 1;
        #1;
        chk("post_rst_req_rdy", bus.req_rdy, 1);
        chk("post_rst_resp_val", bus.resp_val, 0);
        b = got.size();
        send(0, 8'h10, '0, '0, 8'h64);
        drain();
        chk("post_rst_data", got[b].data, PX);
        chk("post_rst_opq", got[b].opq, 8'h64);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
